// File: rtl/lpm_pkg.sv
// Shared types and constants for the longest-prefix-match trie walker.
// The key byte helper picks the 8-bit stride slice that indexes the table at a given depth.
package lpm_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } lpmState_t;

  localparam int          LPM_STRIDE   = 8;
  localparam int          LPM_LEAF_BIT = 31;
  localparam logic [31:0] LPM_MISS     = 32'hFFFF_FFFF;

  // Level 0 uses the most significant byte of the key.
  function automatic logic [7:0] keyByte(input logic [31:0] key, input logic [1:0] level);
    logic [7:0] b;
    case (level)
      2'd0:    b = key[31:24];
      2'd1:    b = key[23:16];
      2'd2:    b = key[15:8];
      default: b = key[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/lpm_walker.sv
// Longest-prefix-match engine: walks an 8-bit-stride multibit trie in external memory,
// one read per level, one lookup in flight, and holds the route until the client accepts it.
module lpm_walker
  import lpm_pkg::*;
#(
  parameter logic [31:0] ROOT_ADDR  = 32'h0,
  parameter int          MAX_LEVELS = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        enter__ENA,
  input  logic [31:0] enter_key,
  output logic        enter__RDY,
  output logic [31:0] resultValue,
  output logic [2:0]  resultLevels,
  output logic        resultValue__RDY,
  input  logic        resultAccept__ENA,
  output logic        resultAccept__RDY,
  output logic        mem_req__ENA,
  output logic [31:0] mem_req_v,
  input  logic        mem_req__RDY,
  output logic        mem_resAccept__ENA,
  input  logic        mem_resAccept__RDY,
  input  logic [31:0] mem_resValue,
  input  logic        mem_resValue__RDY
);

  lpmState_t   stateReg, stateNext;
  logic [31:0] keyReg, keyNext;
  logic [31:0] ptrReg, ptrNext;
  logic [2:0]  levelReg, levelNext;
  logic [31:0] resultReg, resultNext;
  logic [2:0]  levelInc;
  logic        resTake;

  assign levelInc = levelReg + 3'd1;
  assign resTake  = (stateReg == WAIT) && mem_resValue__RDY && mem_resAccept__RDY;

  // Address is live from the registers, so it stays stable while the server stalls the request.
  assign mem_req_v          = ptrReg + {24'b0, keyByte(keyReg, levelReg[1:0])};
  assign mem_req__ENA       = (stateReg == ISSUE) && mem_req__RDY;
  assign mem_resAccept__ENA = resTake;
  assign enter__RDY         = (stateReg == IDLE);
  assign resultValue__RDY   = (stateReg == DONE);
  assign resultAccept__RDY  = (stateReg == DONE);
  assign resultValue        = resultReg;
  assign resultLevels       = levelReg;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stateReg  <= IDLE;
      keyReg    <= 32'h0;
      ptrReg    <= ROOT_ADDR;
      levelReg  <= 3'd0;
      resultReg <= 32'h0;
    end else begin
      stateReg  <= stateNext;
      keyReg    <= keyNext;
      ptrReg    <= ptrNext;
      levelReg  <= levelNext;
      resultReg <= resultNext;
    end
  end

  always_comb begin
    stateNext  = stateReg;
    keyNext    = keyReg;
    ptrNext    = ptrReg;
    levelNext  = levelReg;
    resultNext = resultReg;
    case (stateReg)
      IDLE: begin
        if (enter__ENA) begin
          keyNext   = enter_key;
          ptrNext   = ROOT_ADDR;
          levelNext = 3'd0;
          stateNext = ISSUE;
        end
      end
      ISSUE: begin
        if (mem_req__RDY) stateNext = WAIT;
      end
      WAIT: begin
        if (resTake) begin
          levelNext = levelInc;
          if (mem_resValue[LPM_LEAF_BIT]) begin
            resultNext = {1'b0, mem_resValue[30:0]};
            stateNext  = DONE;
          end else if (levelInc == 3'(MAX_LEVELS)) begin
            // Depth exhausted without reaching a leaf: report a miss.
            resultNext = LPM_MISS;
            stateNext  = DONE;
          end else begin
            ptrNext   = {1'b0, mem_resValue[30:0]};
            stateNext = ISSUE;
          end
        end
      end
      DONE: begin
        if (resultAccept__ENA) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

endmodule

// File: tb/tb_lpm_walker.sv
// Directed bench for lpm_walker against a small behavioural trie memory with
// programmable request backpressure and response delay.
module tb_lpm_walker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enterEna = 1'b0;
  logic [31:0] enterKey = 32'h0;
  logic        enterRdy;
  logic [31:0] resValue;
  logic [2:0]  resLevels;
  logic        resRdy;
  logic        accEna = 1'b0;
  logic        accRdy;
  logic        reqEna;
  logic [31:0] reqAddr;
  logic        reqRdy = 1'b1;
  logic        rspAccEna;
  logic        rspAccRdy = 1'b1;
  logic [31:0] rspValue;
  logic        rspRdy;

  int tests = 0;
  int fails = 0;

  logic [31:0] memArr [logic [31:0]];
  logic [31:0] readLog [$];
  int          respDelay = 1;
  logic        pending;
  int          cnt;
  logic [31:0] pendAddr;

  lpm_walker #(.ROOT_ADDR(32'h0), .MAX_LEVELS(4)) dut (
    .CLK(clk),
    .RST(rst),
    .enter__ENA(enterEna),
    .enter_key(enterKey),
    .enter__RDY(enterRdy),
    .resultValue(resValue),
    .resultLevels(resLevels),
    .resultValue__RDY(resRdy),
    .resultAccept__ENA(accEna),
    .resultAccept__RDY(accRdy),
    .mem_req__ENA(reqEna),
    .mem_req_v(reqAddr),
    .mem_req__RDY(reqRdy),
    .mem_resAccept__ENA(rspAccEna),
    .mem_resAccept__RDY(rspAccRdy),
    .mem_resValue(rspValue),
    .mem_resValue__RDY(rspRdy)
  );

  always #5 clk = ~clk;

  // Memory server: response becomes valid respDelay cycles after the request cycle.
  assign rspRdy   = pending && (cnt == 0);
  assign rspValue = (rspRdy && memArr.exists(pendAddr)) ? memArr[pendAddr] : 32'h0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pending  <= 1'b0;
      cnt      <= 0;
      pendAddr <= 32'h0;
    end else begin
      if (rspAccEna) pending <= 1'b0;
      if (reqEna) begin
        pending  <= 1'b1;
        cnt      <= respDelay - 1;
        pendAddr <= reqAddr;
        readLog.push_back(reqAddr);
      end else if (pending && cnt > 0) begin
        cnt <= cnt - 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the engine idle; returns after the result is accepted.
  task automatic runLookup(input string tag, input logic [31:0] key, input logic [31:0] expVal,
                           input logic [2:0] expLev, input int expReads);
    int i;
    readLog.delete();
    enterKey = key;
    enterEna = 1'b1;
    @(negedge clk);
    enterEna = 1'b0;
    check({tag, "_busy"}, {31'b0, enterRdy}, 32'd0);
    i = 0;
    while (!resRdy && i < 200) begin
      @(negedge clk);
      i++;
    end
    check({tag, "_done"}, {31'b0, resRdy}, 32'd1);
    check({tag, "_value"}, resValue, expVal);
    check({tag, "_levels"}, {29'b0, resLevels}, {29'b0, expLev});
    check({tag, "_reads"}, readLog.size(), expReads);
    accEna = 1'b1;
    @(negedge clk);
    accEna = 1'b0;
    check({tag, "_idle"}, {31'b0, enterRdy}, 32'd1);
    $display("[TB] %s key=0x%08h value=0x%08h levels=%0d reads=%0d", tag, key, resValue, resLevels, readLog.size());
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    memArr[32'h0A]  = 32'h8000_0005;
    memArr[32'h0B]  = 32'h0000_0100;
    memArr[32'h102] = 32'h8000_0077;
    memArr[32'h01]  = 32'h0000_0100;
    memArr[32'h101] = 32'h0000_0200;
    memArr[32'h201] = 32'h0000_0300;
    memArr[32'h301] = 32'h0000_0400;

    // Reset state
    #1;
    check("rst_enterRdy", {31'b0, enterRdy}, 32'd1);
    check("rst_resRdy", {31'b0, resRdy}, 32'd0);
    check("rst_accRdy", {31'b0, accRdy}, 32'd0);
    check("rst_value", resValue, 32'h0);
    check("rst_levels", {29'b0, resLevels}, 32'd0);
    check("rst_reqEna", {31'b0, reqEna}, 32'd0);
    check("rst_rspAccEna", {31'b0, rspAccEna}, 32'd0);
    check("rst_reqAddr", reqAddr, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // One-level lookup with cycle-exact timing
    readLog.delete();
    enterKey = 32'h0A00_0001;
    enterEna = 1'b1;
    @(negedge clk);
    enterEna = 1'b0;
    check("t1_c1_reqEna", {31'b0, reqEna}, 32'd1);
    check("t1_c1_reqAddr", reqAddr, 32'h0A);
    check("t1_c1_enterRdy", {31'b0, enterRdy}, 32'd0);
    @(negedge clk);
    check("t1_c2_rspAcc", {31'b0, rspAccEna}, 32'd1);
    check("t1_c2_reqEna", {31'b0, reqEna}, 32'd0);
    @(negedge clk);
    check("t1_c3_resRdy", {31'b0, resRdy}, 32'd1);
    check("t1_c3_accRdy", {31'b0, accRdy}, 32'd1);
    check("t1_c3_value", resValue, 32'h5);
    check("t1_c3_levels", {29'b0, resLevels}, 32'd1);
    check("t1_c3_enterRdy", {31'b0, enterRdy}, 32'd0);
    check("t1_reads", readLog.size(), 1);
    accEna = 1'b1;
    @(negedge clk);
    accEna = 1'b0;
    check("t1_idle", {31'b0, enterRdy}, 32'd1);
    $display("[TB] t1 key=0x0A000001 value=0x%08h levels=%0d", resValue, resLevels);

    // Two-level lookup
    runLookup("t2", 32'h0B02_0000, 32'h77, 3'd2, 2);
    check("t2_addr0", readLog[0], 32'h0B);
    check("t2_addr1", readLog[1], 32'h102);

    // Four non-leaf levels: miss
    runLookup("t3", 32'h0101_0101, 32'hFFFF_FFFF, 3'd4, 4);
    check("t3_addr3", readLog[3], 32'h301);

    // Request backpressure then slow response
    reqRdy = 1'b0;
    respDelay = 7;
    enterKey = 32'h0A00_0001;
    enterEna = 1'b1;
    @(negedge clk);
    enterEna = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check("t4_stall_reqEna", {31'b0, reqEna}, 32'd0);
      check("t4_stall_addr", reqAddr, 32'h0A);
      @(negedge clk);
    end
    reqRdy = 1'b1;
    #1;
    check("t4_fire_reqEna", {31'b0, reqEna}, 32'd1);
    @(negedge clk);
    for (int k = 0; k < 6; k++) begin
      check("t4_wait_rspAcc", {31'b0, rspAccEna}, 32'd0);
      @(negedge clk);
    end
    check("t4_rspAcc", {31'b0, rspAccEna}, 32'd1);
    @(negedge clk);
    check("t4_value", resValue, 32'h5);
    check("t4_resRdy", {31'b0, resRdy}, 32'd1);
    accEna = 1'b1;
    @(negedge clk);
    accEna = 1'b0;
    respDelay = 1;
    $display("[TB] t4 backpressure lookup value=0x%08h", resValue);

    // Reset in WAIT
    respDelay = 7;
    enterKey = 32'h0B02_0000;
    enterEna = 1'b1;
    @(negedge clk);
    enterEna = 1'b0;
    @(negedge clk);
    check("t5_inWait_enterRdy", {31'b0, enterRdy}, 32'd0);
    #2 rst = 1'b1;
    #1;
    check("t5_rst_enterRdy", {31'b0, enterRdy}, 32'd1);
    check("t5_rst_resRdy", {31'b0, resRdy}, 32'd0);
    check("t5_rst_reqEna", {31'b0, reqEna}, 32'd0);
    check("t5_rst_rspAcc", {31'b0, rspAccEna}, 32'd0);
    #1 rst = 1'b0;
    @(negedge clk);
    respDelay = 1;
    $display("[TB] t5 reset during WAIT");
    runLookup("t5_after", 32'h0B02_0000, 32'h77, 3'd2, 2);

    // Result held in DONE, stray enter ignored
    enterKey = 32'h0A00_0001;
    enterEna = 1'b1;
    @(negedge clk);
    enterEna = 1'b0;
    @(negedge clk);
    @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      enterEna = (k == 4);
      enterKey = 32'h0B02_0000;
      check("t6_hold_resRdy", {31'b0, resRdy}, 32'd1);
      check("t6_hold_value", resValue, 32'h5);
      check("t6_hold_levels", {29'b0, resLevels}, 32'd1);
      @(negedge clk);
    end
    enterEna = 1'b0;
    check("t6_reqEna_quiet", {31'b0, reqEna}, 32'd0);
    accEna = 1'b1;
    @(negedge clk);
    accEna = 1'b0;
    check("t6_idle", {31'b0, enterRdy}, 32'd1);
    check("t6_idle_reqEna", {31'b0, reqEna}, 32'd0);
    $display("[TB] t6 held result value=0x%08h", resValue);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/lpm_walker.md
# lpm_walker

Initiator-side longest-prefix-match lookup engine. Accepts a 32-bit key, walks a multibit trie stored in an external memory through the LpmMem interface (client modport), and presents the final route value. Sits between the packet-classification front end and the LpmMemory server, one lookup in flight at a time.

## Interface

Parameters:
- ROOT_ADDR, 32'h0, memory address of the level-0 node table.
- MAX_LEVELS, 4, trie depth limit (1..4); stride is fixed at 8 bits.

Ports:
- Clocking: one clock; reset is asynchronous and active-high.
- CLK  input  1  clock.
- RST  input  1  asynchronous active-high reset.
- enter__ENA  input  1  start lookup; only asserted when enter__RDY.
- enter$key  input  32  lookup key.
- enter__RDY  output  1  engine idle.
- resultValue  output  32  route value, or 32'hFFFFFFFF on miss.
- resultLevels  output  3  memory reads used (1..MAX_LEVELS).
- resultValue__RDY  output  1  result valid.
- resultAccept__ENA  input  1  consume result; only when resultAccept__RDY.
- resultAccept__RDY  output  1  equals resultValue__RDY.
- mem$req__ENA  output  1  issue read.
- mem$req$v  output  32  read address.
- mem$req__RDY  input  1  server can take a request.
- mem$resAccept__ENA  output  1  consume response.
- mem$resAccept__RDY  input  1  server can retire a response.
- mem$resValue  input  32  response word.
- mem$resValue__RDY  input  1  response word valid.

## Operation

- State machine: IDLE, ISSUE, WAIT, DONE. Registers: key (32), ptr (32), level (3), result (32).
- IDLE: enter__RDY=1. On enter__ENA: key<=enter$key, ptr<=ROOT_ADDR, level<=0, go ISSUE.
- ISSUE: mem$req$v = ptr + {24'b0, key[31-8*level -: 8]}, 32-bit add, wraps modulo 2^32. mem$req__ENA = mem$req__RDY (ENA never asserted without RDY). When asserted, go WAIT.
- WAIT: mem$resAccept__ENA = mem$resValue__RDY & mem$resAccept__RDY. On that cycle, capture mem$resValue = W and level<=level+1.
  - W[31]=1 (leaf): result<={1'b0, W[30:0]}, go DONE.
  - W[31]=0 and level+1 == MAX_LEVELS: result<=32'hFFFFFFFF, go DONE.
  - otherwise: ptr<={1'b0, W[30:0]}, go ISSUE.
- DONE: resultValue__RDY=resultAccept__RDY=1; resultValue=result, resultLevels=level, both held stable. On resultAccept__ENA go IDLE.
- enter__ENA outside IDLE is a protocol violation; engine ignores it.
- All memory-side ENAs are 0 in IDLE and DONE.

## Timing

- Reset values: state=IDLE, enter__RDY=1, resultValue__RDY=0, resultAccept__RDY=0, resultValue=0, resultLevels=0, mem$req__ENA=0, mem$resAccept__ENA=0, mem$req$v=ROOT_ADDR.
- enter at cycle 0 -> earliest mem$req__ENA at cycle 1 -> earliest resAccept at cycle 2. Per level: 1 issue cycle + memory delay (minimum 1). A leaf on the final read raises resultValue__RDY the cycle after resAccept.
- Best-case one-level lookup: enter cycle 0, result valid cycle 3. Against a server with 1-cycle delay: 2 cycles per level.
- New enter is accepted only on the cycle after resultAccept__ENA; there is no back-to-back overlap.
- Backpressure: mem$req__RDY low holds ISSUE with address stable. mem$resValue__RDY low holds WAIT indefinitely; there is no timeout.
- Reset mid-walk: immediate return to IDLE and all ENAs drop asynchronously. The LpmMemory server shares RST, so no stale response survives.

## Structure

- Shared package lpm_pkg:
  - state enum {IDLE, ISSUE, WAIT, DONE}
  - LPM_STRIDE=8
  - LPM_LEAF_BIT=31
  - LPM_MISS=32'hFFFFFFFF
- Single module with no sub-module. Address generation is one adder plus a byte mux and stays inline.

## Test plan

- ROOT_ADDR=0, mem[0x0A]=32'h80000005, key 32'h0A000001 -> one read at 0x0A; result 5, levels 1; enter__RDY is 0 until accept.
- mem[0x0B]=32'h00000100, mem[0x102]=32'h80000077, key 32'h0B020000 -> reads at 0x0B then 0x102; result 0x77, levels 2.
- All four levels non-leaf (tables chained 0x100/0x200/0x300), key 32'h01010101 -> four reads; result 32'hFFFFFFFF, levels 4.
- mem$req__RDY held low 5 cycles during ISSUE -> mem$req__ENA stays 0 and mem$req$v stays stable; the read fires on the first RDY cycle. Response delayed 7 cycles -> no resAccept until valid.
- RST pulsed while in WAIT -> same-cycle enter__RDY=1 and resultValue__RDY=0. A fresh lookup then completes correctly.
- Hold resultAccept__ENA low 10 cycles in DONE -> resultValue and resultLevels stay stable, and a stray enter__ENA is ignored.
